// File: rtl/complex_fu_wb_buffer_pkg.sv
// Shared widths and packet type for the complex FU writeback buffer.
// Widths fall back to core defaults when the global define file is absent.
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif
`ifndef SIZE_PHYSICAL_LOG
`define SIZE_PHYSICAL_LOG 7
`endif
`ifndef EXECUTION_FLAGS
`define EXECUTION_FLAGS 6
`endif

package complex_fu_wb_buffer_pkg;

  localparam int DATA_W   = `SIZE_DATA;
  localparam int PHYS_W   = `SIZE_PHYSICAL_LOG;
  localparam int FLAG_W   = `EXECUTION_FLAGS;
  localparam int RES_W    = 2 * DATA_W;
  localparam int WB_PKT_W = PHYS_W + RES_W + FLAG_W;

  typedef struct packed {
    logic [PHYS_W-1:0] tag;
    logic [RES_W-1:0]  result;
    logic [FLAG_W-1:0] flags;
  } wb_pkt_t;

endpackage

// File: rtl/complex_fu_wb_buffer_fifo.sv
// Writeback queue; extra pointer MSB tells full from empty on wrap.
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign count   = wr_ptr - rd_ptr;
  assign head    = mem[rd_ptr[AW-1:0]];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  // Credits upstream must make this impossible.
  always_ff @(posedge clk) begin
    if (!reset && !flush) assert (!(push && full));
  end

endmodule

// File: rtl/complex_fu_wb_buffer.sv
// Complex ALU result consumer: fixed-latency pipe into a credited
// writeback FIFO.
module complex_fu_wb_buffer
  import complex_fu_wb_buffer_pkg::*;
#(
  parameter int LATENCY   = 4,
  parameter int OUT_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [PHYS_W-1:0] tag_i,
  input  logic [RES_W-1:0]  result_i,
  input  logic [FLAG_W-1:0] flags_i,
  output logic              wb_valid_o,
  input  logic              wb_grant_i,
  output logic [PHYS_W-1:0] wb_tag_o,
  output logic [RES_W-1:0]  wb_result_o,
  output logic [FLAG_W-1:0] wb_flags_o
);

  localparam int CW = $clog2(OUT_DEPTH + 1);

  logic [CW-1:0]               cnt;
  logic                        accept;
  logic                        pop;
  logic                        full;
  logic                        empty;
  logic [$clog2(OUT_DEPTH):0]  fifo_count;
  logic [WB_PKT_W-1:0]         head_raw;
  logic [LATENCY-1:0]          stg_v;
  wb_pkt_t                     in_pkt;
  wb_pkt_t                     head_pkt;

  assign in_pkt  = '{tag: tag_i, result: result_i, flags: flags_i};
  assign ready_o = (cnt < CW'(OUT_DEPTH));
  assign accept  = valid_i & ready_o & ~flush_i;
  assign pop     = wb_valid_o & wb_grant_i;

  for (genvar i = 0; i < LATENCY; i++) begin : g_stage
    logic    v;
    logic    v_in;
    wb_pkt_t d;
    wb_pkt_t d_in;

    if (i == 0) begin : g_first
      assign v_in = accept;
      assign d_in = in_pkt;
    end else begin : g_next
      assign v_in = g_stage[i-1].v;
      assign d_in = g_stage[i-1].d;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset)        v <= 1'b0;
      else if (flush_i) v <= 1'b0;
      else              v <= v_in;
    end

    always_ff @(posedge clk) begin
      d <= d_in;
    end

    assign stg_v[i] = v;
  end

  wb_fifo #(
    .DEPTH (OUT_DEPTH),
    .WIDTH (WB_PKT_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush_i),
    .push  (g_stage[LATENCY-1].v),
    .pop   (pop),
    .din   (g_stage[LATENCY-1].d),
    .full  (full),
    .empty (empty),
    .count (fifo_count),
    .head  (head_raw)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (flush_i) begin
      cnt <= '0;
    end else if (accept && !pop) begin
      cnt <= cnt + 1'b1;
    end else if (pop && !accept) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Credits track exactly what is in the pipe plus the queue.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (int'(cnt) == $countones(stg_v) + int'(fifo_count));
      assert (!(full && !empty && fifo_count != OUT_DEPTH));
    end
  end

  assign head_pkt    = empty ? '0 : wb_pkt_t'(head_raw);
  assign wb_valid_o  = ~empty;
  assign wb_tag_o    = head_pkt.tag;
  assign wb_result_o = head_pkt.result;
  assign wb_flags_o  = head_pkt.flags;

endmodule

// File: tb/tb_complex_fu_wb_buffer.sv
// Directed and random checks for the complex FU writeback buffer.
module tb_complex_fu_wb_buffer;
  import complex_fu_wb_buffer_pkg::*;

  localparam int LAT = 4;
  localparam int DEP = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              flush_i = 1'b0;
  logic              valid_i = 1'b0;
  logic              ready_o;
  logic [PHYS_W-1:0] tag_i = '0;
  logic [RES_W-1:0]  result_i = '0;
  logic [FLAG_W-1:0] flags_i = '0;
  logic              wb_valid_o;
  logic              wb_grant_i = 1'b0;
  logic [PHYS_W-1:0] wb_tag_o;
  logic [RES_W-1:0]  wb_result_o;
  logic [FLAG_W-1:0] wb_flags_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  complex_fu_wb_buffer #(
    .LATENCY   (LAT),
    .OUT_DEPTH (DEP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (flush_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .tag_i       (tag_i),
    .result_i    (result_i),
    .flags_i     (flags_i),
    .wb_valid_o  (wb_valid_o),
    .wb_grant_i  (wb_grant_i),
    .wb_tag_o    (wb_tag_o),
    .wb_result_o (wb_result_o),
    .wb_flags_o  (wb_flags_o)
  );

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({wb_valid_o, wb_tag_o, wb_result_o, wb_flags_o} !== '0) begin
      errors++;
      $display("FAIL reset_outs: got v=%0b tag=%0d res=%h flg=%b want all 0",
               wb_valid_o, wb_tag_o, wb_result_o, wb_flags_o);
    end
    #2 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1", ready_o);
    end
  endtask

  task automatic test_single;
    logic exp_v;
    @(negedge clk);
    valid_i    = 1'b1;
    tag_i      = 7'd5;
    result_i   = 64'h1_0000_0002;
    flags_i    = 6'b011100;
    wb_grant_i = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      valid_i = 1'b0;
      exp_v = (k == LAT + 1);
      checks++;
      if (wb_valid_o !== exp_v) begin
        errors++;
        $display("FAIL single_valid k=%0d: got %b want %b", k, wb_valid_o, exp_v);
      end
      if (k == LAT + 1) begin
        checks++;
        if (wb_tag_o !== 7'd5 || wb_result_o !== 64'h1_0000_0002 ||
            wb_flags_o !== 6'b011100) begin
          errors++;
          $display("FAIL single_fields: got tag=%0d res=%h flg=%b want 5 100000002 011100",
                   wb_tag_o, wb_result_o, wb_flags_o);
        end
      end
    end
    wb_grant_i = 1'b0;
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (ready_o !== (i < DEP)) begin
        errors++;
        $display("FAIL b2b_ready i=%0d: got %b want %b", i, ready_o, i < DEP);
      end
      valid_i = 1'b1;
      tag_i   = PHYS_W'(i + 1);
    end
    @(negedge clk);
    valid_i = 1'b0;
    checks++;
    if (ready_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_full_ready: got %b want 0", ready_o);
    end
    wb_grant_i = 1'b1;
    for (int j = 0; j < 4; j++) begin
      if (j > 0) @(negedge clk);
      checks++;
      if (wb_valid_o !== 1'b1 || wb_tag_o !== PHYS_W'(j + 1)) begin
        errors++;
        $display("FAIL b2b_order j=%0d: got v=%b tag=%0d want v=1 tag=%0d",
                 j, wb_valid_o, wb_tag_o, j + 1);
      end
      if (j == 1) begin
        checks++;
        if (ready_o !== 1'b1) begin
          errors++;
          $display("FAIL b2b_ready_rise: got %b want 1", ready_o);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (wb_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drained: got %b want 0", wb_valid_o);
    end
    wb_grant_i = 1'b0;
  endtask

  // 4 credits each held 6 edges (accept..pop..ready) -> 4 per 6 cycles.
  task automatic test_steady;
    logic [PHYS_W-1:0] next_send = '0;
    logic [PHYS_W-1:0] exp_tag = '0;
    int acc = 0;
    int pops = 0;
    for (int c = 0; c < 68; c++) begin
      @(negedge clk);
      if (wb_valid_o) begin
        checks++;
        if (wb_tag_o !== exp_tag) begin
          errors++;
          $display("FAIL steady_order: got %0d want %0d", wb_tag_o, exp_tag);
        end
        exp_tag++;
        if (c >= 20) pops++;
      end
      valid_i    = 1'b1;
      wb_grant_i = 1'b1;
      tag_i      = next_send;
      if (ready_o) begin
        next_send++;
        if (c >= 20) acc++;
      end
    end
    @(negedge clk);
    valid_i = 1'b0;
    checks++;
    if (acc != 32 || pops != 32) begin
      errors++;
      $display("FAIL steady_rate: got acc=%0d pops=%0d want 32 32", acc, pops);
    end
    for (int c = 0; c < 10; c++) begin
      if (wb_valid_o) begin
        checks++;
        if (wb_tag_o !== exp_tag) begin
          errors++;
          $display("FAIL steady_drain_order: got %0d want %0d", wb_tag_o, exp_tag);
        end
        exp_tag++;
      end
      @(negedge clk);
    end
    checks++;
    if (wb_valid_o !== 1'b0 || exp_tag !== next_send) begin
      errors++;
      $display("FAIL steady_loss: got v=%b delivered_to=%0d want v=0 sent_to=%0d",
               wb_valid_o, exp_tag, next_send);
    end
    wb_grant_i = 1'b0;
  endtask

  task automatic test_flush;
    int seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      valid_i = (c == 0 || c == 1 || c == 4 || c == 5);
      tag_i   = PHYS_W'(20 + (c < 2 ? c : c - 2));
    end
    @(negedge clk);
    checks++;
    if (wb_valid_o !== 1'b1 || wb_tag_o !== 7'd20 || ready_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_setup: got v=%b tag=%0d rdy=%b want 1 20 0",
               wb_valid_o, wb_tag_o, ready_o);
    end
    flush_i    = 1'b1;
    valid_i    = 1'b1;
    tag_i      = 7'd24;
    wb_grant_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    valid_i = 1'b0;
    checks++;
    if (ready_o !== 1'b1 || wb_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_after: got rdy=%b v=%b want 1 0", ready_o, wb_valid_o);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (wb_valid_o) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL flush_leak: got %0d writebacks want 0", seen);
    end
    wb_grant_i = 1'b0;
  endtask

  task automatic test_async_reset;
    int seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      valid_i = (c < 3);
      tag_i   = PHYS_W'(30 + c);
    end
    checks++;
    if (wb_valid_o !== 1'b1 || wb_tag_o !== 7'd30) begin
      errors++;
      $display("FAIL areset_setup: got v=%b tag=%0d want 1 30", wb_valid_o, wb_tag_o);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({wb_valid_o, wb_tag_o, wb_result_o, wb_flags_o} !== '0) begin
      errors++;
      $display("FAIL areset_outs: got v=%b tag=%0d res=%h flg=%b want all 0",
               wb_valid_o, wb_tag_o, wb_result_o, wb_flags_o);
    end
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (ready_o !== 1'b1 || wb_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL areset_post: got rdy=%b v=%b want 1 0", ready_o, wb_valid_o);
    end
    valid_i    = 1'b1;
    tag_i      = 7'd9;
    wb_grant_i = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      valid_i = 1'b0;
      if (wb_valid_o) begin
        seen++;
        checks++;
        if (wb_tag_o !== 7'd9) begin
          errors++;
          $display("FAIL areset_tag: got %0d want 9", wb_tag_o);
        end
      end
    end
    checks++;
    if (seen != 1) begin
      errors++;
      $display("FAIL areset_count: got %0d writebacks want 1", seen);
    end
    wb_grant_i = 1'b0;
  endtask

  task automatic test_random;
    wb_pkt_t mq[$];
    wb_pkt_t sd[LAT];
    bit      sv[LAT];
    wb_pkt_t pkt;
    wb_pkt_t got;
    int      cnt_m;
    bit      exp_rdy;
    bit      exp_wbv;
    bit      v;
    bit      g;
    for (int i = 0; i < LAT; i++) sv[i] = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      cnt_m = mq.size();
      for (int i = 0; i < LAT; i++) cnt_m += int'(sv[i]);
      exp_rdy = (cnt_m < DEP);
      exp_wbv = (mq.size() > 0);
      got = '{tag: wb_tag_o, result: wb_result_o, flags: wb_flags_o};
      checks++;
      if (ready_o !== exp_rdy || wb_valid_o !== exp_wbv) begin
        errors++;
        $display("FAIL rand_hs c=%0d: got rdy=%b v=%b want %b %b",
                 c, ready_o, wb_valid_o, exp_rdy, exp_wbv);
      end
      if (exp_wbv) begin
        checks++;
        if (got !== mq[0]) begin
          errors++;
          $display("FAIL rand_head c=%0d: got %h want %h", c, got, mq[0]);
        end
      end
      v = ($urandom_range(99) < 60);
      g = ($urandom_range(99) < 55);
      pkt.tag    = PHYS_W'($urandom);
      pkt.result = {$urandom, $urandom};
      pkt.flags  = FLAG_W'($urandom);
      valid_i    = v;
      wb_grant_i = g;
      tag_i      = pkt.tag;
      result_i   = pkt.result;
      flags_i    = pkt.flags;
      if (g && exp_wbv) void'(mq.pop_front());
      if (sv[LAT-1]) mq.push_back(sd[LAT-1]);
      for (int i = LAT - 1; i > 0; i--) begin
        sv[i] = sv[i-1];
        sd[i] = sd[i-1];
      end
      sv[0] = v && exp_rdy;
      sd[0] = pkt;
    end
    @(negedge clk);
    valid_i    = 1'b0;
    wb_grant_i = 1'b1;
    repeat (LAT + DEP + 4) @(negedge clk);
    checks++;
    if (wb_valid_o !== 1'b0 || ready_o !== 1'b1) begin
      errors++;
      $display("FAIL rand_drain: got v=%b rdy=%b want 0 1", wb_valid_o, ready_o);
    end
    wb_grant_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_steady();
    test_flush();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
